// File: rtl/alsu_drv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_drv_pkg
//  Description : Shared types and constants for the ALSU stimulus driver.
//                The ALSU_DRV_STATS_EN build macro is consumed by the top.
//  Revision    : 1.0 - initial release
// ============================================================================
package alsu_drv_pkg;

    localparam int unsigned c_default_latency = 2;
    localparam int unsigned c_cmd_w           = 16;
    localparam int unsigned c_cnt_w           = 16;

    // Bit positions of the fields inside the packed command word
    localparam int unsigned c_a_lsb         = 0;
    localparam int unsigned c_b_lsb         = 3;
    localparam int unsigned c_op_lsb        = 6;
    localparam int unsigned c_cin_bit       = 9;
    localparam int unsigned c_serial_in_bit = 10;
    localparam int unsigned c_dir_bit       = 11;
    localparam int unsigned c_red_op_a_bit  = 12;
    localparam int unsigned c_red_op_b_bit  = 13;
    localparam int unsigned c_bypass_a_bit  = 14;
    localparam int unsigned c_bypass_b_bit  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } drv_state_e;

    typedef struct packed {
        logic       bypass_b;
        logic       bypass_a;
        logic       red_op_b;
        logic       red_op_a;
        logic       dir;
        logic       serial_in;
        logic       cin;
        logic [2:0] op;
        logic [2:0] b;
        logic [2:0] a;
    } alsu_pins_t;

    // Bypass of a zero operand: the ALSU outputs 0 and never re-runs a
    // stateful or invalid operation while the driver is not commanding it.
    localparam alsu_pins_t c_idle_pins = '{
        bypass_b  : 1'b0,
        bypass_a  : 1'b1,
        red_op_b  : 1'b0,
        red_op_a  : 1'b0,
        dir       : 1'b0,
        serial_in : 1'b0,
        cin       : 1'b0,
        op        : 3'd0,
        b         : 3'd0,
        a         : 3'd0
    };

    function automatic alsu_pins_t cmd_to_pins(input logic [c_cmd_w-1:0] cmd);
        alsu_pins_t p;
        p.a         = cmd[c_a_lsb  +: 3];
        p.b         = cmd[c_b_lsb  +: 3];
        p.op        = cmd[c_op_lsb +: 3];
        p.cin       = cmd[c_cin_bit];
        p.serial_in = cmd[c_serial_in_bit];
        p.dir       = cmd[c_dir_bit];
        p.red_op_a  = cmd[c_red_op_a_bit];
        p.red_op_b  = cmd[c_red_op_b_bit];
        p.bypass_a  = cmd[c_bypass_a_bit];
        p.bypass_b  = cmd[c_bypass_b_bit];
        return p;
    endfunction

    function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
        return (v == {c_cnt_w{1'b1}}) ? v : v + {{(c_cnt_w-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_drv_if.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_drv_if
//  Description : Command and response valid/ready channels of the driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alsu_drv_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_out;
    logic [15:0] rsp_leds;
    logic        rsp_err;

    // Sequencer side
    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_err
    );

    // Driver side
    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/alsu_drv_stats.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_drv_stats
//  Description : Saturating counters of completed and erroneous responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_drv_stats
    import alsu_drv_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_rsp_done,
    input  wire logic               i_rsp_err,
    output logic [c_cnt_w-1:0]      o_txn_count,
    output logic [c_cnt_w-1:0]      o_err_count
);

    logic [c_cnt_w-1:0] txn_count_q, txn_count_d;
    logic [c_cnt_w-1:0] err_count_q, err_count_d;

    always_comb begin
        txn_count_d = txn_count_q;
        err_count_d = err_count_q;
        if (i_rsp_done) begin
            txn_count_d = sat_inc(txn_count_q);
            if (i_rsp_err) begin
                err_count_d = sat_inc(err_count_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count_q <= '0;
            err_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign o_txn_count = txn_count_q;
    assign o_err_count = err_count_q;

endmodule
`default_nettype wire

// File: rtl/alsu_stim_driver.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_stim_driver
//  Description : One-at-a-time transaction initiator for the registered ALSU.
//                Define ALSU_DRV_STATS_EN to build the txn/err counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_stim_driver
    import alsu_drv_pkg::*;
#(
    parameter int unsigned LATENCY = c_default_latency
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alsu_drv_if.slave         bus,
    output logic [2:0]        alsu_a,
    output logic [2:0]        alsu_b,
    output logic [2:0]        alsu_op,
    output logic              alsu_cin,
    output logic              alsu_serial_in,
    output logic              alsu_dir,
    output logic              alsu_red_op_a,
    output logic              alsu_red_op_b,
    output logic              alsu_bypass_a,
    output logic              alsu_bypass_b,
    input  wire logic [5:0]   alsu_out,
    input  wire logic [15:0]  alsu_leds,
    output logic [15:0]       txn_count,
    output logic [15:0]       err_count
);

    localparam logic [3:0] c_wait_init = 4'(LATENCY - 1);

    drv_state_e  state_q, state_d;
    alsu_pins_t  pins_q, pins_d;
    logic [15:0] leds_pre_q, leds_pre_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [5:0]  rsp_out_q, rsp_out_d;
    logic [15:0] rsp_leds_q, rsp_leds_d;
    logic        rsp_err_q, rsp_err_d;

    always_comb begin
        state_d    = state_q;
        pins_d     = pins_q;
        leds_pre_d = leds_pre_q;
        wait_cnt_d = wait_cnt_q;
        rsp_out_d  = rsp_out_q;
        rsp_leds_d = rsp_leds_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    pins_d     = cmd_to_pins(bus.cmd_data);
                    leds_pre_d = alsu_leds;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                pins_d     = c_idle_pins;
                wait_cnt_d = c_wait_init;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // Any LED movement across the transaction flags an invalid op
                if (wait_cnt_q == 4'd0) begin
                    rsp_out_d  = alsu_out;
                    rsp_leds_d = alsu_leds;
                    rsp_err_d  = (alsu_leds != leds_pre_q);
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pins_d  = c_idle_pins;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pins_q     <= c_idle_pins;
            leds_pre_q <= '0;
            wait_cnt_q <= '0;
            rsp_out_q  <= '0;
            rsp_leds_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pins_q     <= pins_d;
            leds_pre_q <= leds_pre_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_out_q  <= rsp_out_d;
            rsp_leds_q <= rsp_leds_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_leds  = rsp_leds_q;
    assign bus.rsp_err   = rsp_err_q;

    assign alsu_a         = pins_q.a;
    assign alsu_b         = pins_q.b;
    assign alsu_op        = pins_q.op;
    assign alsu_cin       = pins_q.cin;
    assign alsu_serial_in = pins_q.serial_in;
    assign alsu_dir       = pins_q.dir;
    assign alsu_red_op_a  = pins_q.red_op_a;
    assign alsu_red_op_b  = pins_q.red_op_b;
    assign alsu_bypass_a  = pins_q.bypass_a;
    assign alsu_bypass_b  = pins_q.bypass_b;

`ifdef ALSU_DRV_STATS_EN
    logic w_rsp_done;
    assign w_rsp_done = (state_q == ST_RESP) && bus.rsp_ready;

    alsu_drv_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .i_rsp_done  (w_rsp_done),
        .i_rsp_err   (rsp_err_q),
        .o_txn_count (txn_count),
        .o_err_count (err_count)
    );
`else
    assign txn_count = '0;
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alsu_stim_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alsu_stim_driver
//  Description : Self-checking bench with a behavioural ALSU and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_stim_driver;

    localparam int LAT = 2;
    localparam logic [15:0] c_idle_vec = 16'h4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alsu_drv_if bus();

    logic [2:0]  alsu_a, alsu_b, alsu_op;
    logic        alsu_cin, alsu_serial_in, alsu_dir, alsu_red_op_a, alsu_red_op_b;
    logic        alsu_bypass_a, alsu_bypass_b;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic [15:0] txn_count, err_count;

    alsu_stim_driver #(.LATENCY(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .alsu_a         (alsu_a),
        .alsu_b         (alsu_b),
        .alsu_op        (alsu_op),
        .alsu_cin       (alsu_cin),
        .alsu_serial_in (alsu_serial_in),
        .alsu_dir       (alsu_dir),
        .alsu_red_op_a  (alsu_red_op_a),
        .alsu_red_op_b  (alsu_red_op_b),
        .alsu_bypass_a  (alsu_bypass_a),
        .alsu_bypass_b  (alsu_bypass_b),
        .alsu_out       (alsu_out),
        .alsu_leds      (alsu_leds),
        .txn_count      (txn_count),
        .err_count      (err_count)
    );

    logic [15:0] pins_vec;
    assign pins_vec = {alsu_bypass_b, alsu_bypass_a, alsu_red_op_b, alsu_red_op_a,
                       alsu_dir, alsu_serial_in, alsu_cin, alsu_op, alsu_b, alsu_a};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int v);
`ifdef ALSU_DRV_STATS_EN
        return 16'(v);
`else
        return (v < 0) ? 16'd1 : 16'd0;
`endif
    endfunction

    // Behavioural ALSU: {invalid, out} for a command given the previous output
    function automatic logic [6:0] alsu_calc(input logic [15:0] c, input logic [5:0] prev);
        logic [2:0] a, b, op;
        logic       cin, si, dir, ra, rb, ba, bb, inv;
        logic [5:0] o;
        a = c[2:0]; b = c[5:3]; op = c[8:6];
        cin = c[9]; si = c[10]; dir = c[11]; ra = c[12]; rb = c[13]; ba = c[14]; bb = c[15];
        inv = (op == 3'b110) || (op == 3'b111) || ((ra || rb) && op != 3'b000 && op != 3'b001);
        o = '0;
        if (inv)     o = '0;
        else if (ba) o = {3'b0, a};
        else if (bb) o = {3'b0, b};
        else begin
            case (op)
                3'b000:  o = ra ? {5'b0, &a} : rb ? {5'b0, &b} : {3'b0, a & b};
                3'b001:  o = ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b0, a ^ b};
                3'b010:  o = {3'b0, a} + {3'b0, b} + {5'b0, cin};
                3'b011:  o = {3'b0, a} * {3'b0, b};
                3'b100:  o = dir ? {prev[4:0], si} : {si, prev[5:1]};
                3'b101:  o = dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
                default: o = '0;
            endcase
        end
        return {inv, o};
    endfunction

    // ALSU environment: input register stage then output register stage
    logic [15:0] env_s1;
    logic [5:0]  env_out;
    logic [15:0] env_leds;
    logic [6:0]  env_calc;
    assign env_calc  = alsu_calc(env_s1, env_out);
    assign alsu_out  = env_out;
    assign alsu_leds = env_leds;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            env_s1   <= '0;
            env_out  <= '0;
            env_leds <= '0;
        end else begin
            env_s1  <= pins_vec;
            env_out <= env_calc[5:0];
            if (env_calc[6]) env_leds <= ~env_leds;
        end
    end

    // Scoreboard: every accepted command yields one response in order
    logic [15:0] sb_q[$];
    logic [15:0] ref_leds = '0;
    int          sb_txn = 0;
    int          sb_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q.delete();
            ref_leds = '0;
            sb_txn   = 0;
            sb_err   = 0;
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    logic [15:0] c;
                    logic [6:0]  r;
                    c = sb_q.pop_front();
                    r = alsu_calc(c, 6'd0);
                    if (r[6]) ref_leds = ~ref_leds;
                    check("sb_out",  {26'd0, bus.rsp_out}, {26'd0, r[5:0]});
                    check("sb_leds", {16'd0, bus.rsp_leds}, {16'd0, ref_leds});
                    check("sb_err",  {31'd0, bus.rsp_err}, {31'd0, r[6]});
                    sb_txn++;
                    if (r[6]) sb_err++;
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) sb_q.push_back(bus.cmd_data);
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic issue(input logic [15:0] c);
        int n = 0;
        bus.cmd_data  = c;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("cmd_accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("pins_drive", {16'd0, pins_vec}, {16'd0, c});
    endtask

    // Counts negedges from the accept edge until rsp_valid is seen
    task automatic wait_rsp(input logic rdy, output int lat);
        lat = 1;
        bus.rsp_ready = rdy;
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 2) check("pins_idle_after_drive", {16'd0, pins_vec}, {16'd0, c_idle_vec});
        end
        if (lat >= 100) check("rsp_valid_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [5:0]  out;
        logic [15:0] leds;
        logic        err;
        int          errs;
    } vec_t;

    vec_t tv[10];

    initial begin
        int          lat;
        logic [5:0]  s_out;
        logic [15:0] s_leds;
        logic        s_err;
        logic        never;
        int          acc_t[10];
        int          nacc;
        logic        acc_prev;

        tv[0] = '{16'h001D, 6'd1,  16'h0000, 1'b0, 0};  // and 5&3
        tv[1] = '{16'h00FF, 6'd49, 16'h0000, 1'b0, 0};  // mult 7*7
        tv[2] = '{16'h0180, 6'd0,  16'hFFFF, 1'b1, 1};  // invalid op 110
        tv[3] = '{16'h0180, 6'd0,  16'h0000, 1'b1, 2};  // repeat toggles back
        tv[4] = '{16'h02B7, 6'd14, 16'h0000, 1'b0, 2};  // add 7+6+cin
        tv[5] = '{16'h1080, 6'd0,  16'hFFFF, 1'b1, 3};  // reduction on add: invalid
        tv[6] = '{16'h2078, 6'd1,  16'hFFFF, 1'b0, 3};  // xor-reduce b=7
        tv[7] = '{16'h80E8, 6'd5,  16'hFFFF, 1'b0, 3};  // bypass_b
        tv[8] = '{16'h0D00, 6'd1,  16'hFFFF, 1'b0, 3};  // shift left, serial_in=1
        tv[9] = '{16'h0500, 6'h20, 16'hFFFF, 1'b0, 3};  // shift right, serial_in=1

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_out",   {26'd0, bus.rsp_out}, 32'd0);
        check("rst_rsp_leds",  {16'd0, bus.rsp_leds}, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rst_pins",      {16'd0, pins_vec}, {16'd0, c_idle_vec});
        check("rst_txn_count", {16'd0, txn_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(tv[i].cmd);
            wait_rsp(1'b1, lat);
            check("tv_latency", lat, LAT + 2);
            check("tv_rsp_out",  {26'd0, bus.rsp_out}, {26'd0, tv[i].out});
            check("tv_rsp_leds", {16'd0, bus.rsp_leds}, {16'd0, tv[i].leds});
            check("tv_rsp_err",  {31'd0, bus.rsp_err}, {31'd0, tv[i].err});
            @(negedge clk);
            check("tv_txn_count", {16'd0, txn_count}, {16'd0, exp_cnt(i + 1)});
            check("tv_err_count", {16'd0, err_count}, {16'd0, exp_cnt(tv[i].errs)});
        end

        // Backpressure with a pending command
        issue(16'h00FF);
        wait_rsp(1'b0, lat);
        s_out = bus.rsp_out; s_leds = bus.rsp_leds; s_err = bus.rsp_err;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'h001D;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check("bp_stable", {9'd0, bus.rsp_err, bus.rsp_leds, bus.rsp_out},
                               {9'd0, s_err, s_leds, s_out});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_done_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("bp_pending_not_taken", {16'd0, pins_vec}, {16'd0, c_idle_vec});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("bp_pending_taken", {16'd0, pins_vec}, 32'h001D);
        wait_rsp(1'b1, lat);
        check("bp_next_out", {26'd0, bus.rsp_out}, 32'd1);
        @(negedge clk);

        // Reset while waiting on the ALSU
        issue(16'h00FF);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("mrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mrst_pins", {16'd0, pins_vec}, {16'd0, c_idle_vec});
        check("mrst_rsp", {9'd0, bus.rsp_err, bus.rsp_leds, bus.rsp_out}, 32'd0);
        check("mrst_txn_count", {16'd0, txn_count}, 32'd0);
        #1 rst = 1'b0;
        never = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) never = 1'b0;
        end
        check("mrst_no_rsp", {31'd0, never}, 32'd1);
        issue(16'h001D);
        wait_rsp(1'b1, lat);
        check("mrst_next_lat", lat, LAT + 2);
        check("mrst_next_out", {26'd0, bus.rsp_out}, 32'd1);
        @(negedge clk);
        check("mrst_next_txn", {16'd0, txn_count}, {16'd0, exp_cnt(1)});

        // Back-to-back: cmd_valid and rsp_ready held high
        nacc = 0;
        acc_prev = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 16'($urandom);
        for (int k = 0; k < 300 && nacc < 10; k++) begin
            if (acc_prev) bus.cmd_data = 16'($urandom);
            acc_prev = bus.cmd_ready;
            if (bus.cmd_ready) begin
                acc_t[nacc] = k;
                nacc++;
            end
            if (nacc < 10) @(negedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("b2b_accepts", nacc, 10);
        for (int i = 1; i < nacc; i++) check("b2b_period", acc_t[i] - acc_t[i-1], LAT + 3);
        begin
            int n = 0;
            while ((!bus.cmd_ready || sb_q.size() != 0) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("b2b_txn_count", {16'd0, txn_count}, {16'd0, exp_cnt(11)});

        // Randomized traffic with random gaps and backpressure
        for (int i = 0; i < 40; i++) begin
            int gap, hold;
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            issue(16'($urandom));
            wait_rsp(hold == 0, lat);
            check("rnd_latency", lat, LAT + 2);
            repeat (hold) @(negedge clk);
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        check("end_txn_count", {16'd0, txn_count}, {16'd0, exp_cnt(sb_txn)});
        check("end_err_count", {16'd0, err_count}, {16'd0, exp_cnt(sb_err)});
        check("end_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alsu_stim_driver.md
# alsu_stim_driver

Transaction-level initiator for the registered 3-bit ALSU. It accepts one packed command through a valid/ready handshake and drives the ALSU input pins for exactly one cycle. After the ALSU pipeline latency it captures the ALSU result and LED state, then returns a response through a second valid/ready handshake. It sits between the bench or sequencer and the ALSU, and is the only agent driving ALSU inputs.

## Interface
Parameters:
- LATENCY, 2, ALSU input-to-output register depth in cycles; legal range 1–15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_data  in  16  command word:
  - [2:0] a, [5:3] b, [8:6] op.
  - [9] cin, [10] serial_in, [11] dir.
  - [12] red_op_a, [13] red_op_b, [14] bypass_a, [15] bypass_b.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_out  out  6  captured ALSU result.
- rsp_leds  out  16  captured ALSU LED value.
- rsp_err  out  1  LEDs changed during this transaction (invalid-op indication).
- alsu_a, alsu_b, alsu_op  out  3 each  ALSU operand and opcode pins.
- alsu_cin, alsu_serial_in, alsu_dir, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b  out  1 each  ALSU control pins.
- alsu_out  in  6  ALSU result.
- alsu_leds  in  16  ALSU LED bus.
- txn_count  out  16  completed responses.
- err_count  out  16  responses with rsp_err=1.

## Operation
- FSM states: IDLE, DRIVE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register cmd_data onto the alsu_* pins, snapshot alsu_leds into leds_pre, go to DRIVE.
- DRIVE: lasts one cycle with the pins carrying the command. Then the pins switch to the IDLE pattern and the FSM goes to WAIT with wait_cnt=LATENCY-1.
- IDLE pattern: alsu_bypass_a=1, all other pins 0. The ALSU therefore produces 0 and never re-executes shift, rotate or invalid ops.
- WAIT:
  - wait_cnt decrements each cycle.
  - In the cycle where wait_cnt==0: capture rsp_out<=alsu_out, rsp_leds<=alsu_leds, rsp_err<=(alsu_leds!=leds_pre), then go to RESP.
  - With LATENCY=1, WAIT lasts one cycle.
- RESP:
  - rsp_valid=1; rsp_* are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: increment txn_count, increment err_count if rsp_err, go to IDLE.
- cmd_ready=0 in DRIVE, WAIT and RESP. There is one outstanding transaction at a time.
- Counters saturate at 16'hFFFF.
- Any 16-bit command is accepted, including op 110/111. Invalid-op detection is purely by LED change.

## Timing
- Reset values:
  - State IDLE, cmd_ready=1, rsp_valid=0.
  - rsp_out=0, rsp_leds=0, rsp_err=0.
  - alsu_* pins at the IDLE pattern (bypass_a=1, rest 0).
  - txn_count=0, err_count=0, leds_pre=0, wait_cnt=0.
- Accept at edge E0. Pins carry the command from E0 to E1.
- Capture at edge E(1+LATENCY); rsp_valid rises after that edge.
  - LATENCY=2: accept at E0, capture at E3, rsp_valid high in the cycle after E3.
- Minimum transaction period, with rsp_ready held high: LATENCY+3 cycles, accept to accept.
- rsp_ready high in the same cycle rsp_valid rises completes the response in one cycle.
- Reset asserted mid-transaction (any state): immediate return to the reset values, and the in-flight response is discarded. The ALSU itself is reset by the shared rst.
- cmd_valid while not ready: ignored. The command must be held by the source, per standard valid/ready rules.

## Configuration
- ALSU_DRV_STATS_EN defined: txn_count and err_count are implemented as described.
- ALSU_DRV_STATS_EN undefined: both ports are tied to 0, no counter flops exist, and all other behaviour is identical.

## Structure
- Package alsu_drv_pkg holds:
  - state enum (IDLE, DRIVE, WAIT, RESP);
  - cmd_data field bit-position constants;
  - IDLE pin-pattern constant;
  - default LATENCY.
- Sub-module alsu_drv_stats: saturating txn/err counters, instantiated only under ALSU_DRV_STATS_EN.
- FSM and capture logic stay in the top module.

## Test plan
- Command a=5, b=3, op=000, all flags 0, rsp_ready=1 → rsp_out=6'd1, rsp_err=0, rsp_valid high 4 cycles after accept (LATENCY=2).
- Multiply a=7, b=7, op=011 → rsp_out=6'd49, rsp_err=0, txn_count=1.
- Invalid op=110, flags 0, starting from leds=0 → rsp_leds=16'hFFFF, rsp_err=1, err_count=1. Repeat the command → rsp_leds=0, rsp_err=1, err_count=2.
- rsp_ready held low for 5 cycles in RESP → rsp_* stable, cmd_ready=0, and a pending cmd_valid is not accepted until the cycle after the rsp handshake.
- rst pulsed during WAIT → rsp_valid never rises, pins return to the IDLE pattern, and the next command completes normally.
- Ten back-to-back commands with cmd_valid and rsp_ready held high → accepts exactly 5 cycles apart, txn_count=10.
